// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Default value written into every entry by the clear sweep.
  localparam logic [31:0] INIT_VAL_DEF = 32'h5;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: clear control, two write ports, NUM_RD read ports, status pulses.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     clr_req;
  logic                     busy;
  logic                     wr_en0;
  logic [ADDR_W-1:0]        wr_addr0;
  logic [DATA_W-1:0]        wr_data0;
  logic                     wr_en1;
  logic [ADDR_W-1:0]        wr_addr1;
  logic [DATA_W-1:0]        wr_data1;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_conflict;
  logic                     wr_drop;

  modport master (
    output clr_req, wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, rd_addr,
    input  busy, rd_data, wr_conflict, wr_drop
  );

  modport slave (
    input  clr_req, wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, rd_addr,
    output busy, rd_data, wr_conflict, wr_drop
  );
endinterface

// File: rtl/regfile_mp_clr_fsm.sv
// Clear-sweep controller: walks ptr over every entry once, raising busy and the clear strobe.
module regfile_mp_clr_fsm
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset starts a fresh sweep from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: clr_req only matters in IDLE, so a request mid-sweep cannot extend it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins), NUM_RD combinational read ports,
// and a clear sweep that loads INIT_VAL into every entry after reset or on request.
// Optional macro REGFILE_MP_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                NUM_RD   = 2,
  parameter int                ZERO_REG = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_VAL_DEF)
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic                         busy, clr_we;
  logic [ADDR_W-1:0]            clr_addr;
  logic                         zero0, zero1, acc0, acc1;
  logic                         conflict_q, conflict_d, drop_q, drop_d;
  logic [ADDR_W-1:0]            ra    [NUM_RD];
  logic [DATA_W-1:0]            rd_v  [NUM_RD];

  regfile_mp_clr_fsm #(.ADDR_W(ADDR_W)) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  // Write acceptance: entry 0 is silently immune when hardwired, everything else only lands in IDLE.
  always_comb begin
    zero0      = (ZERO_REG != 0) && (bus.wr_addr0 == '0);
    zero1      = (ZERO_REG != 0) && (bus.wr_addr1 == '0);
    acc0       = bus.wr_en0 && !busy && !zero0;
    acc1       = bus.wr_en1 && !busy && !zero1;
    conflict_d = acc0 && acc1 && (bus.wr_addr0 == bus.wr_addr1);
    drop_d     = busy && ((bus.wr_en0 && !zero0) || (bus.wr_en1 && !zero1));
  end

  // Next array contents: sweep strobe, then port 0, then port 1 so port 1 wins a same-address tie.
  always_comb begin
    mem_d = mem_q;
    if (clr_we) mem_d[clr_addr]      = INIT_VAL;
    if (acc0)   mem_d[bus.wr_addr0]  = bus.wr_data0;
    if (acc1)   mem_d[bus.wr_addr1]  = bus.wr_data1;
  end

  // Storage array; the clear sweep provides its initial contents, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Status pulses, one cycle after the offending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.wr_conflict = conflict_q;
  assign bus.wr_drop     = drop_q;

  // Read ports: array lookup, optional forwarding, busy override, then the hardwired-zero mask.
  always_comb begin
    bus.rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra[k]   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rd_v[k] = mem_q[ra[k]];
`ifdef REGFILE_MP_BYPASS_EN
      if (acc0 && (bus.wr_addr0 == ra[k])) rd_v[k] = bus.wr_data0;
      if (acc1 && (bus.wr_addr1 == ra[k])) rd_v[k] = bus.wr_data1;
`endif
      if (busy) rd_v[k] = INIT_VAL;
      if ((ZERO_REG != 0) && (ra[k] == '0)) rd_v[k] = '0;
      bus.rd_data[k*DATA_W +: DATA_W] = rd_v[k];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations are queued as stimulus is driven and
// drained against the DUT outputs. Honors REGFILE_MP_BYPASS_EN when defined.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  localparam int K_RD0  = 0;
  localparam int K_RD1  = 1;
  localparam int K_BUSY = 2;
  localparam int K_CONF = 3;
  localparam int K_DROP = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [DEPTH];
  int          n;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_exp(input int a, input bit in_sweep);
    if (a == 0) return 32'h0;
    if (in_sweep) return 32'h5;
    return mdl[a];
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD0:   act = bus.rd_data[31:0];
        K_RD1:   act = bus.rd_data[63:32];
        K_BUSY:  act = {31'b0, bus.busy};
        K_CONF:  act = {31'b0, bus.wr_conflict};
        default: act = {31'b0, bus.wr_drop};
      endcase
      chk(e.tag, act, e.exp);
    end
  endtask

  task automatic idle_in();
    bus.clr_req  = 1'b0;
    bus.wr_en0   = 1'b0;
    bus.wr_addr0 = '0;
    bus.wr_data0 = '0;
    bus.wr_en1   = 1'b0;
    bus.wr_addr1 = '0;
    bus.wr_data1 = '0;
  endtask

  // Drive both read addresses, let them settle, then compare against the model.
  task automatic rd2(input int a0, input int a1, input string tag, input bit in_sweep);
    bus.rd_addr = {a1[ADDR_W-1:0], a0[ADDR_W-1:0]};
    #1;
    push({tag, "_p0"}, K_RD0, rd_exp(a0, in_sweep));
    push({tag, "_p1"}, K_RD1, rd_exp(a1, in_sweep));
    drain();
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic sweep_model();
    for (int a = 0; a < DEPTH; a++) mdl[a] = 32'h5;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    bus.rd_addr = '0;
    rst = 1'b1;
    #1;
    push("rst_busy", K_BUSY, 32'd1);
    push("rst_conf", K_CONF, 32'd0);
    push("rst_drop", K_DROP, 32'd0);
    drain();
    rd2(0, 5, "rst_rd", 1'b1);

    // Reset release: sweep length and post-sweep contents.
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("rst_sweep_len", n, 32);
    sweep_model();
    for (int a = 0; a < DEPTH; a++) rd2(a, DEPTH - 1 - a, "init_rd", 1'b0);

    // Same-address dual write: port 1 wins, conflict pulses one cycle.
    @(negedge clk);
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd3; bus.wr_data0 = 32'hAAAA;
    bus.wr_en1 = 1'b1; bus.wr_addr1 = 5'd3; bus.wr_data1 = 32'hBBBB;
    bus.rd_addr = {5'd0, 5'd3};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    push("conf_same_cyc", K_RD0, 32'hBBBB);
`else
    push("conf_same_cyc", K_RD0, 32'h5);
`endif
    push("conf_pre", K_CONF, 32'd0);
    drain();
    @(negedge clk);
    idle_in();
    mdl[3] = 32'hBBBB;
    push("conf_pulse", K_CONF, 32'd1);
    push("conf_nodrop", K_DROP, 32'd0);
    drain();
    rd2(3, 4, "conf_rd", 1'b0);
    @(negedge clk);
    push("conf_clr", K_CONF, 32'd0);
    drain();

    // Distinct dual write.
    @(negedge clk);
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd10; bus.wr_data0 = 32'hA0A0_0001;
    bus.wr_en1 = 1'b1; bus.wr_addr1 = 5'd11; bus.wr_data1 = 32'hC1C1_0002;
    @(negedge clk);
    idle_in();
    mdl[10] = 32'hA0A0_0001;
    mdl[11] = 32'hC1C1_0002;
    push("dual_noconf", K_CONF, 32'd0);
    drain();
    rd2(10, 11, "dual_rd", 1'b0);

    // Write/read same address in the same cycle.
    @(negedge clk);
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd7; bus.wr_data0 = 32'h1234;
    bus.rd_addr = {5'd10, 5'd7};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    push("byp_same_cyc", K_RD0, 32'h1234);
`else
    push("byp_same_cyc", K_RD0, 32'h5);
`endif
    drain();
    @(negedge clk);
    idle_in();
    mdl[7] = 32'h1234;
    rd2(7, 3, "byp_next", 1'b0);

    // Writes to the hardwired zero entry vanish without flags.
    @(negedge clk);
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd0; bus.wr_data0 = 32'hFFFF;
    bus.wr_en1 = 1'b1; bus.wr_addr1 = 5'd0; bus.wr_data1 = 32'hEEEE;
    bus.rd_addr = {5'd0, 5'd0};
    #1;
    push("zero_same_cyc", K_RD0, 32'h0);
    drain();
    @(negedge clk);
    idle_in();
    push("zero_noconf", K_CONF, 32'd0);
    push("zero_nodrop", K_DROP, 32'd0);
    drain();
    rd2(0, 7, "zero_rd", 1'b0);

    // Requested clear with a dropped write and a redundant clr_req mid-sweep.
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    push("clr_busy", K_BUSY, 32'd1);
    drain();
    n = 0;
    while (bus.busy && n < 100) begin
      case (n)
        12: begin bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd9; bus.wr_data0 = 32'hDEAD; end
        13: begin bus.wr_en0 = 1'b0; push("drop_pulse", K_DROP, 32'd1); drain(); end
        14: begin push("drop_clr", K_DROP, 32'd0); drain(); end
        20: bus.clr_req = 1'b1;
        21: bus.clr_req = 1'b0;
        25: rd2(3, 0, "clr_mid_rd", 1'b1);
        default: ;
      endcase
      @(negedge clk);
      n++;
    end
    chk("clr_sweep_len", n, 32);
    sweep_model();
    rd2(9, 3, "clr_after", 1'b0);
    rd2(7, 0, "clr_after2", 1'b0);

    // Reset in the middle of a sweep restarts it from the beginning.
    @(negedge clk);
    bus.wr_en0 = 1'b1; bus.wr_addr0 = 5'd12; bus.wr_data0 = 32'h7777;
    @(negedge clk);
    idle_in();
    mdl[12] = 32'h7777;
    rd2(12, 11, "pre_rst_rd", 1'b0);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    push("mid_rst_busy", K_BUSY, 32'd1);
    push("mid_rst_conf", K_CONF, 32'd0);
    push("mid_rst_drop", K_DROP, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("mid_rst_sweep_len", n, 32);
    sweep_model();
    rd2(12, 31, "mid_rst_rd", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.
REQ-005 Parameter INIT_VAL, 32'h5, value loaded into every entry by the clear sweep.
REQ-006 clk  in  1  single clock, all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 clr_req  in  1  request a full clear sweep; sampled only in IDLE.
REQ-009 busy  out  1  high while the clear sweep runs.
REQ-010 wr_en0 / wr_addr0 / wr_data0  in  1/ADDR_W/DATA_W  write port 0.
REQ-011 wr_en1 / wr_addr1 / wr_data1  in  1/ADDR_W/DATA_W  write port 1, higher priority.
REQ-012 rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-014 wr_conflict  out  1  one-cycle pulse: both ports wrote the same address.
REQ-015 wr_drop  out  1  one-cycle pulse: a write arrived while busy and was discarded.

Function
REQ-016 FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req, CLEAR->IDLE after entry DEPTH-1 is written.
REQ-017 CLEAR writes INIT_VAL to entry ptr each cycle and increments ptr from 0; the sweep lasts exactly DEPTH cycles; busy = (state==CLEAR).
REQ-018 clr_req during CLEAR is ignored; the sweep is neither restarted nor extended.
REQ-019 In IDLE, each enabled write port updates its entry at the clock edge; both ports may write distinct entries in the same cycle.
REQ-020 Same-address dual write: port 1 data stored; wr_conflict high the following cycle for one cycle.
REQ-021 Any wr_en while busy: write discarded; wr_drop high the following cycle for one cycle.
REQ-022 Reads are combinational from the array, zero added latency, all NUM_RD ports independent.
REQ-023 While busy, every rd_data port returns INIT_VAL regardless of address.
REQ-024 ZERO_REG=1: reads of address 0 return 0 (including while busy); writes to 0 are discarded without wr_drop or wr_conflict.

Reset
REQ-025 rst asserted: state=CLEAR, ptr=0, busy=1, wr_conflict=0, wr_drop=0, immediately and asynchronously.
REQ-026 After rst deasserts, the sweep runs DEPTH cycles, then busy falls; reset mid-sweep restarts it at ptr=0.

Configuration
REQ-027 Macro REGFILE_MP_BYPASS_EN defined: a read whose address matches an enabled, accepted write in the same cycle returns that write data (port 1 wins on dual match, ZERO_REG rule still applies).
REQ-028 Macro undefined: reads return the pre-edge stored value; the new value is visible the cycle after the write.

Structure
REQ-029 Package regfile_mp_pkg holds the state enum (IDLE, CLEAR) and the default INIT_VAL constant.
REQ-030 Sub-module regfile_mp_clr_fsm owns state, ptr, busy and the clear write strobe; the array and write/read muxing stay in regfile_mp.

Verification
REQ-031 Release rst at cycle 0, DEPTH=32 -> busy high for exactly 32 cycles; every address then reads 32'h5, address 0 reads 0.
REQ-032 wr_en0=1, addr 3, data 32'hAAAA; wr_en1=1, addr 3, data 32'hBBBB -> entry 3 = 32'hBBBB, wr_conflict pulses one cycle later.
REQ-033 Write addr 7 = 32'h1234 with rd_addr port 0 = 7 in the same cycle -> with REGFILE_MP_BYPASS_EN reads 32'h1234 that cycle; without it reads 32'h5, then 32'h1234 next cycle.
REQ-034 clr_req in IDLE after loading entries -> busy for 32 cycles, reads return 32'h5 during and after; clr_req mid-sweep does not extend busy.
REQ-035 wr_en0 on addr 9 while busy -> entry 9 remains 32'h5 after the sweep, wr_drop pulses one cycle.
REQ-036 Assert rst at sweep ptr=20 -> busy stays high, ptr restarts at 0, sweep completes 32 cycles after release.
